// File: rtl/dram_cmd_scheduler.sv
// dram_cmd_scheduler
//   Turns one memory request at a time into a legal DDR4 command sequence
//   (ACT/RD/WR/PRE/PREA/REF) for the downstream dram_command block.
//   Open-page policy with per-bank open-row tracking. tRCD, tRP, tRAS, tCCD
//   and tRFC are enforced, and refresh is periodic at tREFI. All timings are
//   in CLK cycles.
//
//   Optional build macro: DRAM_SCHED_CLOSED_PAGE_EN
//     When it is defined, every access is followed by a PRE of the same bank
//     (after its tCCD wait and honouring tRAS), then tRP, then IDLE.
//
// Ports
//   CLK, nRST           clock, asynchronous active-low reset
//   req_valid/req_ready request handshake (ready only in IDLE, no refresh due)
//   req_write           1 = write, 0 = read
//   req_addr            {row, bg, ba, col}
//   done                one-cycle pulse when the request's RD/WR is accepted
//   cmd_valid/cmd_ready command handshake toward dram_command
//   cmd                 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA, 6 REF
//   cmd_bg, cmd_ba      target bank group / bank
//   cmd_row             row (ACT only, else 0)
//   cmd_col             column (RD/WR only, else 0)
module dram_cmd_scheduler #(
  parameter int ROW_W  = 16,
  parameter int COL_W  = 10,
  parameter int BG_W   = 2,
  parameter int BA_W   = 2,
  parameter int T_RCD  = 14,
  parameter int T_RP   = 14,
  parameter int T_RAS  = 32,
  parameter int T_CCD  = 4,
  parameter int T_RFC  = 208,
  parameter int T_REFI = 6240
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [ROW_W+BG_W+BA_W+COL_W-1:0] req_addr,
  output logic                           done,
  output logic                           cmd_valid,
  input  logic                           cmd_ready,
  output logic [2:0]                     cmd,
  output logic [BG_W-1:0]                cmd_bg,
  output logic [BA_W-1:0]                cmd_ba,
  output logic [ROW_W-1:0]               cmd_row,
  output logic [COL_W-1:0]               cmd_col
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int          BK_W   = BG_W + BA_W;
  localparam int unsigned NB     = 1 << BK_W;
  localparam int          T_MAX  = imax(imax(T_RCD, T_RP), imax(T_CCD, T_RFC));
  localparam int          WAIT_W = $clog2(T_MAX + 1);
  localparam int          RAS_W  = $clog2(T_RAS + 1);
  localparam int          REF_W  = $clog2(T_REFI + 1);

`ifdef DRAM_SCHED_CLOSED_PAGE_EN
  localparam bit CLOSE_PAGE = 1'b1;
`else
  localparam bit CLOSE_PAGE = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_PRE, S_ACT, S_RW, S_PREA, S_REF, S_WAIT
  } state_t;

  typedef enum logic [2:0] {
    C_NOP = 3'd0, C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3,
    C_PRE = 3'd4, C_PREA = 3'd5, C_REF = 3'd6
  } cmd_t;

  state_t               state, state_d, ret_st, ret_d;
  logic                 live;
  logic                 wr_q;
  logic [ROW_W-1:0]     row_q;
  logic [BG_W-1:0]      bg_q;
  logic [BA_W-1:0]      ba_q;
  logic [COL_W-1:0]     col_q;
  logic [BK_W-1:0]      bank_q;
  logic [WAIT_W-1:0]    wait_cnt, wait_ld;
  logic [REF_W-1:0]     ref_cnt;
  logic                 ref_pending;
  logic [NB-1:0]        open_valid;
  logic [ROW_W-1:0]     open_row [NB];
  logic [RAS_W-1:0]     ras_cnt  [NB];

  logic                 issue, act_iss, pre_iss, prea_iss, ref_iss;
  logic                 accept, hit, ras_all_zero;

  assign bank_q = {bg_q, ba_q};
  assign hit    = open_valid[bank_q] && (open_row[bank_q] == row_q);
  assign issue  = cmd_valid && cmd_ready;
  assign accept = req_valid && req_ready;

  always_comb begin
    ras_all_zero = 1'b1;
    for (int unsigned i = 0; i < NB; i++) begin
      if (ras_cnt[i] != '0) ras_all_zero = 1'b0;
    end
  end

  always_comb begin
    state_d   = state;
    ret_d     = ret_st;
    req_ready = 1'b0;
    done      = 1'b0;
    cmd_valid = 1'b0;
    cmd       = C_NOP;
    cmd_bg    = '0;
    cmd_ba    = '0;
    cmd_row   = '0;
    cmd_col   = '0;
    wait_ld   = '0;
    act_iss   = 1'b0;
    pre_iss   = 1'b0;
    prea_iss  = 1'b0;
    ref_iss   = 1'b0;
    case (state)
      S_IDLE: begin
        // live keeps req_ready low until the first edge after reset.
        req_ready = live && !ref_pending;
        if (live && ref_pending)  state_d = (|open_valid) ? S_PREA : S_REF;
        else if (accept)          state_d = S_DECODE;
      end
      S_DECODE: begin
        if (hit)                          state_d = S_RW;
        else if (!open_valid[bank_q])     state_d = S_ACT;
        else                              state_d = S_PRE;
      end
      S_PRE: begin
        if (ras_cnt[bank_q] == '0) begin
          cmd_valid = 1'b1;
          cmd       = C_PRE;
          cmd_bg    = bg_q;
          cmd_ba    = ba_q;
          if (cmd_ready) begin
            pre_iss = 1'b1;
            wait_ld = WAIT_W'(T_RP - 1);
            state_d = S_WAIT;
            ret_d   = CLOSE_PAGE ? S_IDLE : S_ACT;
          end
        end
      end
      S_ACT: begin
        cmd_valid = 1'b1;
        cmd       = C_ACT;
        cmd_bg    = bg_q;
        cmd_ba    = ba_q;
        cmd_row   = row_q;
        if (cmd_ready) begin
          act_iss = 1'b1;
          wait_ld = WAIT_W'(T_RCD - 1);
          state_d = S_WAIT;
          ret_d   = S_RW;
        end
      end
      S_RW: begin
        cmd_valid = 1'b1;
        cmd       = wr_q ? C_WR : C_RD;
        cmd_bg    = bg_q;
        cmd_ba    = ba_q;
        cmd_col   = col_q;
        if (cmd_ready) begin
          done    = 1'b1;
          wait_ld = WAIT_W'(T_CCD - 1);
          state_d = S_WAIT;
          ret_d   = CLOSE_PAGE ? S_PRE : S_IDLE;
        end
      end
      S_PREA: begin
        if (ras_all_zero) begin
          cmd_valid = 1'b1;
          cmd       = C_PREA;
          if (cmd_ready) begin
            prea_iss = 1'b1;
            wait_ld  = WAIT_W'(T_RP - 1);
            state_d  = S_WAIT;
            ret_d    = S_REF;
          end
        end
      end
      S_REF: begin
        cmd_valid = 1'b1;
        cmd       = C_REF;
        if (cmd_ready) begin
          ref_iss = 1'b1;
          wait_ld = WAIT_W'(T_RFC - 1);
          state_d = S_WAIT;
          ret_d   = S_IDLE;
        end
      end
      S_WAIT: begin
        // Leaving at count 1 means the target state is entered as the count
        // reaches 0, so issue-to-issue spacing equals the timing value.
        if (wait_cnt <= WAIT_W'(1)) state_d = ret_st;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= S_IDLE;
      ret_st      <= S_IDLE;
      live        <= 1'b0;
      wr_q        <= 1'b0;
      row_q       <= '0;
      bg_q        <= '0;
      ba_q        <= '0;
      col_q       <= '0;
      wait_cnt    <= '0;
      ref_cnt     <= REF_W'(T_REFI);
      ref_pending <= 1'b0;
      open_valid  <= '0;
      for (int unsigned i = 0; i < NB; i++) begin
        open_row[i] <= '0;
        ras_cnt[i]  <= '0;
      end
    end else begin
      state  <= state_d;
      ret_st <= ret_d;
      live   <= 1'b1;

      if (state == S_IDLE && accept) begin
        wr_q                       <= req_write;
        {row_q, bg_q, ba_q, col_q} <= req_addr;
      end

      if (issue)                wait_cnt <= wait_ld;
      else if (wait_cnt != '0)  wait_cnt <= wait_cnt - 1'b1;

      // A fresh expiry wins over a REF issued on the same edge.
      if (ref_cnt == REF_W'(1)) begin
        ref_cnt     <= REF_W'(T_REFI);
        ref_pending <= 1'b1;
      end else begin
        ref_cnt <= ref_cnt - 1'b1;
        if (ref_iss) ref_pending <= 1'b0;
      end

      for (int unsigned i = 0; i < NB; i++) begin
        if (act_iss && BK_W'(i) == bank_q) ras_cnt[i] <= RAS_W'(T_RAS - 1);
        else if (ras_cnt[i] != '0)         ras_cnt[i] <= ras_cnt[i] - 1'b1;
      end

      if (prea_iss) begin
        open_valid <= '0;
      end else if (pre_iss) begin
        open_valid[bank_q] <= 1'b0;
      end else if (act_iss) begin
        open_valid[bank_q] <= 1'b1;
        open_row[bank_q]   <= row_q;
      end
    end
  end

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
module tb_dram_cmd_scheduler;

  localparam int ROW_W  = 16;
  localparam int COL_W  = 10;
  localparam int BG_W   = 2;
  localparam int BA_W   = 2;
  localparam int T_RCD  = 14;
  localparam int T_RP   = 14;
  localparam int T_RAS  = 32;
  localparam int T_CCD  = 4;
  localparam int T_RFC  = 208;
  localparam int T_REFI = 100;
  localparam int AW     = ROW_W + BG_W + BA_W + COL_W;

  localparam int K_ACT = 1, K_RD = 2, K_WR = 3, K_PRE = 4, K_PREA = 5, K_REF = 6;

  logic              CLK = 1'b0;
  logic              nRST = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [AW-1:0]     req_addr = '0;
  logic              done;
  logic              cmd_valid;
  logic              cmd_ready = 1'b1;
  logic [2:0]        cmd;
  logic [BG_W-1:0]   cmd_bg;
  logic [BA_W-1:0]   cmd_ba;
  logic [ROW_W-1:0]  cmd_row;
  logic [COL_W-1:0]  cmd_col;

  dram_cmd_scheduler #(
    .ROW_W(ROW_W), .COL_W(COL_W), .BG_W(BG_W), .BA_W(BA_W),
    .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .T_CCD(T_CCD),
    .T_RFC(T_RFC), .T_REFI(T_REFI)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .done(done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_col(cmd_col)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: per-request command list ----------------
  typedef struct { int kind; int bg; int ba; int row; int col; } mcmd_t;
  typedef struct { int cyc; int cmd; int bg; int ba; int row; int col; } ev_t;

  mcmd_t m_q[$];
  ev_t   log_q[$];
  int    cyc = 0;
  bit    m_in_rst = 1'b1;
  int    c_rst = 0;
  bit    m_pend;
  bit    m_open [16];
  int    m_row [16];
  int    m_ras_free [16];
  int    m_idle_from;
  int    m_nb;

  int    e_rr, e_cv, e_cmd, e_bg, e_ba, e_row, e_col, e_done;

  function automatic void push_cmd(input int kind, input int bg, input int ba,
                                   input int row, input int col);
    mcmd_t c;
    c.kind = kind; c.bg = bg; c.ba = ba; c.row = row; c.col = col;
    m_q.push_back(c);
  endfunction

  function automatic int gap_of(input int kind);
    case (kind)
      K_ACT:        return T_RCD;
      K_RD, K_WR:   return T_CCD;
      K_PRE, K_PREA: return T_RP;
      default:      return T_RFC;
    endcase
  endfunction

  always @(negedge CLK) begin : compare
    mcmd_t h;
    bit    ok, ref_done, any_open;
    int    b, a, mx;
    if (!nRST) begin
      m_in_rst = 1'b1;
      check("reset_outputs",
            {req_ready, done, cmd_valid, cmd, cmd_bg, cmd_ba, cmd_row, cmd_col}, 0);
    end else begin
      if (m_in_rst) begin
        m_in_rst = 1'b0;
        c_rst = cyc;
        m_pend = 1'b0;
        m_q.delete();
        for (int i = 0; i < 16; i++) begin
          m_open[i] = 1'b0; m_row[i] = 0; m_ras_free[i] = 0;
        end
        m_idle_from = cyc + 1;
        m_nb = 0;
      end
      e_rr = 0; e_cv = 0; e_cmd = 0; e_bg = 0; e_ba = 0;
      e_row = 0; e_col = 0; e_done = 0;
      ref_done = 1'b0;
      if (m_q.size() == 0) begin
        if (cyc >= m_idle_from) begin
          e_rr = m_pend ? 0 : 1;
          if (m_pend) begin
            any_open = 1'b0;
            for (int i = 0; i < 16; i++) if (m_open[i]) any_open = 1'b1;
            if (any_open) push_cmd(K_PREA, 0, 0, 0, 0);
            push_cmd(K_REF, 0, 0, 0, 0);
            m_nb = cyc + 1;
          end else if (req_valid) begin
            a = int'(req_addr);
            push_cmd(0, (a >> 12) % 4, (a >> 10) % 4, a >> 14, a % 1024);
            h = m_q.pop_front();
            b = h.bg * 4 + h.ba;
            if (m_open[b] && m_row[b] == h.row) begin
            end else if (!m_open[b]) begin
              push_cmd(K_ACT, h.bg, h.ba, h.row, 0);
            end else begin
              push_cmd(K_PRE, h.bg, h.ba, 0, 0);
              push_cmd(K_ACT, h.bg, h.ba, h.row, 0);
            end
            push_cmd(req_write ? K_WR : K_RD, h.bg, h.ba, 0, h.col);
            m_nb = cyc + 2;
          end
        end
      end else begin
        h = m_q[0];
        b = h.bg * 4 + h.ba;
        ok = (cyc >= m_nb);
        if (h.kind == K_PRE && cyc < m_ras_free[b]) ok = 1'b0;
        if (h.kind == K_PREA) begin
          mx = 0;
          for (int i = 0; i < 16; i++) if (m_ras_free[i] > mx) mx = m_ras_free[i];
          if (cyc < mx) ok = 1'b0;
        end
        if (ok) begin
          e_cv = 1; e_cmd = h.kind;
          if (h.kind != K_PREA && h.kind != K_REF) begin e_bg = h.bg; e_ba = h.ba; end
          if (h.kind == K_ACT) e_row = h.row;
          if (h.kind == K_RD || h.kind == K_WR) e_col = h.col;
          if (cmd_ready) begin
            if (h.kind == K_RD || h.kind == K_WR) e_done = 1;
            case (h.kind)
              K_ACT: begin m_open[b] = 1'b1; m_row[b] = h.row; m_ras_free[b] = cyc + T_RAS; end
              K_PRE: m_open[b] = 1'b0;
              K_PREA: for (int i = 0; i < 16; i++) m_open[i] = 1'b0;
              K_REF: ref_done = 1'b1;
              default: ;
            endcase
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_idle_from = cyc + gap_of(h.kind);
            else                 m_nb = cyc + gap_of(h.kind);
          end
        end
      end
      check("req_ready", req_ready, e_rr);
      check("cmd_valid", cmd_valid, e_cv);
      check("cmd",       cmd,       e_cmd);
      check("cmd_bg",    cmd_bg,    e_bg);
      check("cmd_ba",    cmd_ba,    e_ba);
      check("cmd_row",   cmd_row,   e_row);
      check("cmd_col",   cmd_col,   e_col);
      check("done",      done,      e_done);
      if (cmd_valid && cmd_ready) begin
        ev_t e;
        e.cyc = cyc; e.cmd = int'(cmd); e.bg = int'(cmd_bg); e.ba = int'(cmd_ba);
        e.row = int'(cmd_row); e.col = int'(cmd_col);
        log_q.push_back(e);
      end
      if (ref_done) m_pend = 1'b0;
      if ((cyc + 1 - c_rst) % T_REFI == 0) m_pend = 1'b1;
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  function automatic ev_t get_ev(input int idx);
    ev_t e;
    if (idx >= 0 && idx < log_q.size()) return log_q[idx];
    e.cyc = -1000; e.cmd = -1; e.bg = -1; e.ba = -1; e.row = -1; e.col = -1;
    return e;
  endfunction

  function automatic int find_cmd(input int kind, input int from);
    for (int i = from; i < log_q.size(); i++) if (log_q[i].cmd == kind) return i;
    return -1;
  endfunction

  task automatic release_reset();
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    nRST = 1'b0; req_valid = 1'b0; cmd_ready = 1'b1;
    release_reset();
  endtask

  task automatic send(input bit wr, input int row, input int bg, input int ba, input int col);
    bit got = 1'b0;
    req_addr  = {16'(row), 2'(bg), 2'(ba), 10'(col)};
    req_write = wr;
    req_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (req_ready) begin got = 1'b1; break; end
    end
    @(posedge CLK);
    #1 req_valid = 1'b0;
    check("req_accept", got, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base, base2, i0, i1, i2, i3, i4, held, rr_hi;
    ev_t a0, r1, r2, p0, a1, w0, e0, e1;

    // Open-page basics: miss, hit, conflict.
    release_reset();
    base = log_q.size();
    send(0, 5, 1, 2, 8);
    send(0, 5, 1, 2, 3);
    send(1, 9, 1, 2, 100);
    repeat (70) @(posedge CLK);
    #1;
    a0 = get_ev(base);     r1 = get_ev(base + 1); r2 = get_ev(base + 2);
    p0 = get_ev(base + 3); a1 = get_ev(base + 4); w0 = get_ev(base + 5);
    check("s1_act_cmd", a0.cmd, K_ACT);
    check("s1_act_bg", a0.bg, 1);
    check("s1_act_ba", a0.ba, 2);
    check("s1_act_row", a0.row, 5);
    check("s1_rd_cmd", r1.cmd, K_RD);
    check("s1_trcd", r1.cyc - a0.cyc, 14);
    check("s1_rd_col", r1.col, 8);
    check("s2_hit_rd_cmd", r2.cmd, K_RD);
    check("s2_hit_spacing", r2.cyc - r1.cyc, 6);
    check("s2_rd_col", r2.col, 3);
    check("s3_pre_cmd", p0.cmd, K_PRE);
    check("s3_tras", p0.cyc - a0.cyc, 32);
    check("s3_act_cmd", a1.cmd, K_ACT);
    check("s3_trp", a1.cyc - p0.cyc, 14);
    check("s3_act_row", a1.row, 9);
    check("s3_wr_cmd", w0.cmd, K_WR);
    check("s3_trcd", w0.cyc - a1.cyc, 14);
    check("s3_wr_col", w0.col, 100);

    // Back-pressure on ACT.
    do_reset();
    base = log_q.size();
    cmd_ready = 1'b0;
    send(1, 7, 3, 1, 4);
    held = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (cmd_valid) break;
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge CLK);
      check("s5_hold_cmd", cmd, K_ACT);
      check("s5_hold_row", cmd_row, 7);
      check("s5_hold_bg", cmd_bg, 3);
      held++;
    end
    @(posedge CLK);
    #1 cmd_ready = 1'b1;
    repeat (25) @(posedge CLK);
    #1;
    a0 = get_ev(base); w0 = get_ev(base + 1);
    check("s5_act_cmd", a0.cmd, K_ACT);
    check("s5_act_ba", a0.ba, 1);
    check("s5_wr_cmd", w0.cmd, K_WR);
    check("s5_trcd_from_accept", w0.cyc - a0.cyc, 14);
    check("s5_wr_col", w0.col, 4);

    // Reset while waiting after ACT.
    do_reset();
    base = log_q.size();
    send(0, 2, 0, 0, 1);
    repeat (4) @(posedge CLK);
    #3 nRST = 1'b0;
    #1 check("s6_async_reset_outputs",
             {req_ready, done, cmd_valid, cmd, cmd_bg, cmd_ba, cmd_row, cmd_col}, 0);
    release_reset();
    base2 = log_q.size();
    check("s6_cmds_before_reset", base2 - base, 1);
    send(0, 2, 0, 0, 1);
    repeat (25) @(posedge CLK);
    #1;
    e0 = get_ev(base2); e1 = get_ev(base2 + 1);
    check("s6_first_cmd_is_act", e0.cmd, K_ACT);
    check("s6_act_row", e0.row, 2);
    check("s6_rd_after_act", e1.cyc - e0.cyc, 14);

    // Refresh expiring while a request is in flight.
    do_reset();
    repeat (90) @(posedge CLK);
    #1;
    base = log_q.size();
    send(0, 4, 2, 3, 5);
    i4 = -1;
    for (int i = 0; i < 400; i++) begin
      @(posedge CLK);
      i4 = find_cmd(K_REF, base);
      if (i4 >= 0) break;
    end
    check("s4_ref_seen", (i4 >= 0) ? 1 : 0, 1);
    i0 = find_cmd(K_ACT, base);
    i1 = find_cmd(K_RD, base);
    i2 = find_cmd(K_PREA, base);
    i3 = i4;
    a0 = get_ev(i0); r1 = get_ev(i1); p0 = get_ev(i2); e0 = get_ev(i3);
    check("s4_rd_col", r1.col, 5);
    check("s4_rd_before_prea", (i1 >= 0 && i2 > i1) ? 1 : 0, 1);
    check("s4_prea_tras", p0.cyc - a0.cyc, 32);
    check("s4_ref_trp", e0.cyc - p0.cyc, 14);
    rr_hi = 0;
    req_valid = 1'b1;
    for (int i = 0; i < 206; i++) begin
      @(negedge CLK);
      if (req_ready) rr_hi++;
    end
    check("s4_req_ready_low_in_trfc", rr_hi, 0);
    @(posedge CLK);
    #1 req_valid = 1'b0;
    repeat (10) @(posedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
